// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op codes, FSM states and helpers for the multiply/divide unit
package muldiv_unit_pkg;

    localparam int MD_ITER_CYCLES = 32;
    localparam int MD_OP_W        = 3;

    // Op codes shared with the instruction decoder
    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MFHI  = 3'd4;
    localparam logic [2:0] MD_OP_MFLO  = 3'd5;
    localparam logic [2:0] MD_OP_MTHI  = 3'd6;
    localparam logic [2:0] MD_OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Two's-complement magnitude; unsigned operands pass through untouched
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - shared shift/add multiply and restoring divide datapath, one bit per step
module muldiv_iter
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] load_lo,
    input  logic [31:0] load_b,
    output logic [31:0] acc_hi,
    output logic [31:0] acc_lo
);

    // acc_hi: product high half or partial remainder
    // acc_lo: multiplier being shifted out / dividend shifted out while quotient bits shift in
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] b_q;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;

    // A set multiplier LSB adds the multiplicand; the carry lands in bit 32
    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : 32'd0)};
    // Remainder shifts left taking the next dividend bit; the 33rd bit keeps the compare exact
    assign div_shift = {hi_q, lo_q[31]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    // When div_ge holds the true difference is below 2^32, so the low word is exact
    assign div_diff  = div_shift[31:0] - b_q;

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

    // Operand load at accept, then one multiply or divide bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            b_q  <= 32'd0;
        end else if (load) begin
            hi_q <= 32'd0;
            lo_q <= load_lo;
            b_q  <= load_b;
        end else if (step) begin
            if (is_div) begin
                hi_q <= div_ge ? div_diff : div_shift[31:0];
                lo_q <= {lo_q[30:0], div_ge};
            end else begin
                hi_q <= mul_sum[32:1];
                lo_q <= {mul_sum[0], lo_q[31:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int ITER_CYCLES = MD_ITER_CYCLES,
    parameter int OP_W        = MD_OP_W
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [OP_W-1:0] op_code,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [31:0]     result,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);

    localparam int CNT_W = $clog2(ITER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

    md_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic            is_div_q;
    logic            neg_lo_q;
    logic            neg_hi_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;

    logic        accept;
    logic        is_md;
    logic        op_signed;
    logic        op_div;
    logic        div_zero;
    logic        start;
    logic        step;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] load_lo;
    logic [31:0] load_b;
    logic        start_neg_lo;
    logic        start_neg_hi;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [63:0] prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign busy   = (state != MD_IDLE);
    assign stall  = op_valid & busy;
    assign accept = op_valid & (state == MD_IDLE) & ~flush;

    assign is_md     = (op_code == MD_OP_MULT) || (op_code == MD_OP_MULTU) ||
                       (op_code == MD_OP_DIV)  || (op_code == MD_OP_DIVU);
    assign op_signed = (op_code == MD_OP_MULT) || (op_code == MD_OP_DIV);
    assign op_div    = (op_code == MD_OP_DIV)  || (op_code == MD_OP_DIVU);
    // Divide by zero runs the raw dividend through so it lands in HI untouched
    assign div_zero  = op_div && (rt_val == 32'd0);
    assign start     = accept & is_md;
    assign step      = (state == MD_RUN) & ~flush;

    assign rs_mag = md_abs(rs_val, op_signed & ~div_zero);
    assign rt_mag = md_abs(rt_val, op_signed);

    // Divide: dividend shifts through acc_lo; multiply: multiplier shifts through acc_lo
    assign load_lo = op_div ? rs_mag : rt_mag;
    assign load_b  = op_div ? rt_mag : rs_mag;

    // Quotient/product negates when signs differ; remainder follows the dividend
    assign start_neg_lo = op_signed & ~div_zero & (rs_val[31] ^ rt_val[31]);
    assign start_neg_hi = (op_code == MD_OP_DIV) & ~div_zero & rs_val[31];

    muldiv_iter u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start),
        .step    (step),
        .is_div  (is_div_q),
        .load_lo (load_lo),
        .load_b  (load_b),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo)
    );

    assign prod = {acc_hi, acc_lo};

    // Sign correction of the magnitude result ahead of the HI/LO write
    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (is_div_q) begin
            if (neg_lo_q) fix_lo = 32'd0 - acc_lo;
            if (neg_hi_q) fix_hi = 32'd0 - acc_hi;
        end else if (neg_lo_q) begin
            {fix_hi, fix_lo} = 64'd0 - prod;
        end
    end

    // MFHI/MFLO read path, zero unless a move-from is accepted this cycle
    always_comb begin
        result = 32'd0;
        if (accept && (op_code == MD_OP_MFHI)) result = hi_q;
        if (accept && (op_code == MD_OP_MFLO)) result = lo_q;
    end

    assign hi = hi_q;
    assign lo = lo_q;

    // Control FSM: accept, 32 iterations, then sign fix and HI/LO write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (accept) begin
                        if (op_code == MD_OP_MTHI) hi_q <= rs_val;
                        if (op_code == MD_OP_MTLO) lo_q <= rs_val;
                        if (is_md) begin
                            state    <= MD_RUN;
                            cnt      <= '0;
                            is_div_q <= op_div;
                            neg_lo_q <= start_neg_lo;
                            neg_hi_q <= start_neg_hi;
                        end
                    end
                end
                MD_RUN: begin
                    if (flush) begin
                        state <= MD_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= MD_FIX;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    if (!flush) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .result   (result),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          ncyc;
    } hilo_t;

    typedef struct {
        logic [31:0] val;
        int          stalls;
    } opx_t;

    hilo_t hq[$];
    opx_t  oq[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          busy_end = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural result of a multiply/divide op: {hi, lo}
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        if (op == OP_MULT) begin
            res = sa * sb;
        end else if (op == OP_MULTU) begin
            res = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            res[31:0]  = a / b;
            res[63:32] = a % b;
        end
        return res;
    endfunction

    // Monitor: busy falling ends an operation; an unstalled op_valid is an acceptance
    int bcnt = 0;
    int scnt = 0;
    always @(negedge clk) begin
        hilo_t h;
        opx_t  o;
        if (busy) begin
            bcnt++;
        end else if (bcnt > 0) begin
            if (hq.size() == 0) begin
                chk("hilo_unexpected", 64'd1, 64'd0);
            end else begin
                h = hq.pop_front();
                chk("hi", 64'(hi), 64'(h.hi));
                chk("lo", 64'(lo), 64'(h.lo));
                chk("busy_cycles", 64'(bcnt), 64'(h.ncyc));
            end
            bcnt = 0;
        end
        if (op_valid) begin
            if (stall) begin
                scnt++;
            end else begin
                if (oq.size() == 0) begin
                    chk("op_unexpected", 64'd1, 64'd0);
                end else begin
                    o = oq.pop_front();
                    chk("stall_cycles", 64'(scnt), 64'(o.stalls));
                    chk("result", 64'(result), 64'(o.val));
                end
                scnt = 0;
            end
        end
    end

    // Issue one op; drop=1 flushes it in the same cycle, f>0 flushes a mul/div after f busy cycles
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit drop, input int f);
        opx_t        o;
        hilo_t       h;
        logic [63:0] r;
        int          st, e0, n;
        st = (busy_end > cyc) ? (busy_end - cyc) : 0;
        e0 = cyc + st + 1;
        o.val    = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
        o.stalls = st;
        if (drop) o.val = 32'd0;
        oq.push_back(o);
        if (!drop) begin
            if (op == OP_MTHI) m_hi = a;
            if (op == OP_MTLO) m_lo = a;
            if (op <= OP_DIVU) begin
                r = ref_md(op, a, b);
                h.ncyc = (f > 0) ? f : 33;
                if (f == 0) {m_hi, m_lo} = r;
                h.hi = m_hi;
                h.lo = m_lo;
                hq.push_back(h);
                busy_end = e0 + h.ncyc;
            end
        end
        op_valid = 1'b1;
        op_code  = op;
        rs_val   = a;
        rt_val   = b;
        flush    = drop;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("stall_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        op_code  = 3'($urandom);
        rs_val   = $urandom;
        rt_val   = $urandom;
        if (op <= OP_DIVU && f > 0 && !drop) begin
            repeat (f - 1) begin
                @(posedge clk);
                #1;
            end
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[6] = '{
        '{OP_MULT,  32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB},
        '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001},
        '{OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000},
        '{OP_DIVU,  32'd5,         32'd0,          32'h0000_0005, 32'hFFFF_FFFF},
        '{OP_DIV,   32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF}
    };

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        int         f;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 0);
            wait_idle();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
        end

        issue(OP_MULT, 32'd1234, 32'hFFFF_FF00, 1'b0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 0);
        wait_idle();

        issue(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, 0);
        issue(OP_MULT, 32'd2, 32'd3, 1'b0, 10);
        wait_idle();
        chk("flush_hi_kept", 64'(hi), 64'h1234);

        issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, 0);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, 0);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 33);
        wait_idle();
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 0);

        for (int it = 0; it < 45; it++) begin
            wait_idle();
            op = 3'($urandom_range(0, 7));
            if (op <= OP_DIVU) begin
                f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : 0;
                issue(op, pick(), pick(), 1'b0, f);
            end else if (op >= OP_MTHI && $urandom_range(0, 3) == 0) begin
                issue(op, $urandom, 32'd0, 1'b1, 0);
            end else begin
                issue(op, $urandom, $urandom, 1'b0, 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 4)) begin
                    @(posedge clk);
                    #1;
                end
                issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b0, 0);
            end
        end

        wait_idle();
        issue(OP_MULTU, 32'hFFFF_0001, 32'h0001_FFFF, 1'b0, 0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        hq[hq.size() - 1].hi = 32'd0;
        hq[hq.size() - 1].lo = 32'd0;
        hq[hq.size() - 1].ncyc = 12;
        m_hi = 32'd0;
        m_lo = 32'd0;
        busy_end = cyc;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, 0);

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("hilo_queue_drained", 64'(hq.size()), 64'd0);
        chk("op_queue_drained", 64'(oq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
